// File: rtl/tt_aiju_bus_pkg.sv
// Shared definitions for the 8080 byte-serial bus target: transfer phases,
// FSM states and bit positions of the core's uo_out handshake pins.
package tt_aiju_bus_pkg;

    localparam logic [1:0] PH_ADDR_LO = 2'd0;
    localparam logic [1:0] PH_ADDR_HI = 2'd1;
    localparam logic [1:0] PH_DATA    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEMREQ,
        ST_RSP,
        ST_SETUP,
        ST_ACK,
        ST_REL
    } state_t;

    localparam int UO_REQ  = 0;
    localparam int UO_WR   = 1;
    localparam int UO_RD   = 2;
    localparam int UO_HALT = 3;

    // The data phase is always followed by a fresh address-low phase.
    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        return (ph == PH_DATA) ? PH_ADDR_LO : ph + 2'd1;
    endfunction

endpackage

// File: rtl/tt_aiju_sync.sv
// STAGES-deep flop synchroniser for one asynchronous control bit,
// cleared to 0 by the asynchronous reset.
module tt_aiju_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    generate
        if (STAGES == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) chain <= '0;
                else     chain <= d;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) chain <= '0;
                else     chain <= {chain[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = chain[STAGES-1];

endmodule

// File: rtl/tt_um_aiju_bus_target.sv
// Target end of the 8080 core's byte-serial bus: three 4-phase handshakes
// (addr lo, addr hi, data) become one valid/ready memory request.
module tt_um_aiju_bus_target
    import tt_aiju_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_SETUP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic        bus_halt,
    output logic        bus_ack,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic        halted,
    output logic        proto_err
);

    localparam logic [2:0] SETUP_LAST = (DATA_SETUP > 0) ? 3'(DATA_SETUP - 1) : 3'd0;

    logic [3:0] uo_raw;
    logic [3:0] uo_s;
    logic       req_s;
    logic       wr_s;
    logic       rd_s;

    always_comb begin
        uo_raw          = '0;
        uo_raw[UO_REQ]  = bus_req;
        uo_raw[UO_WR]   = bus_wr;
        uo_raw[UO_RD]   = bus_rd;
        uo_raw[UO_HALT] = bus_halt;
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_sync
            tt_aiju_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (uo_raw[i]),
                .q   (uo_s[i])
            );
        end
    endgenerate

    assign req_s  = uo_s[UO_REQ];
    assign wr_s   = uo_s[UO_WR];
    assign rd_s   = uo_s[UO_RD];
    assign halted = uo_s[UO_HALT];

    state_t     state;
    logic [1:0] phase;
    logic [7:0] addr_lo;
    logic [7:0] addr_hi;
    logic [2:0] setup_cnt;

    // mem_addr is a separate copy so it stays put while the next address bytes arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase     <= PH_ADDR_LO;
            addr_lo   <= '0;
            addr_hi   <= '0;
            setup_cnt <= '0;
            bus_ack   <= 1'b0;
            bus_oe    <= 1'b0;
            bus_dout  <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus_ack <= 1'b0;
                    bus_oe  <= 1'b0;
                    if (req_s) begin
                        case (phase)
                            PH_ADDR_LO: begin
                                addr_lo <= bus_din;
                                bus_ack <= 1'b1;
                                state   <= ST_ACK;
                            end
                            PH_ADDR_HI: begin
                                addr_hi <= bus_din;
                                bus_ack <= 1'b1;
                                state   <= ST_ACK;
                            end
                            default: begin
                                mem_addr  <= {addr_hi, addr_lo};
                                mem_valid <= 1'b1;
                                state     <= ST_MEMREQ;
                                if (wr_s && !rd_s) begin
                                    mem_wdata <= bus_din;
                                    mem_we    <= 1'b1;
                                end else begin
                                    mem_we <= 1'b0;
                                    if (wr_s && rd_s) proto_err <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_MEMREQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_we) begin
                            bus_ack <= 1'b1;
                            state   <= ST_ACK;
                        end else begin
                            state <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (mem_rvalid) begin
                        bus_dout  <= mem_rdata;
                        bus_oe    <= 1'b1;
                        setup_cnt <= '0;
                        if (DATA_SETUP == 0) begin
                            bus_ack <= 1'b1;
                            state   <= ST_ACK;
                        end else begin
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt == SETUP_LAST) begin
                        bus_ack <= 1'b1;
                        state   <= ST_ACK;
                    end else begin
                        setup_cnt <= setup_cnt + 3'd1;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        bus_ack <= 1'b0;
                        bus_oe  <= 1'b0;
                        state   <= ST_REL;
                    end
                end
                ST_REL: begin
                    phase <= next_phase(phase);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_aiju_bus_target.sv
// Directed bench for tt_um_aiju_bus_target: a core-side handshake driver and
// a simple memory responder, with hand-computed expectations per scenario.
module tb_tt_um_aiju_bus_target;

    logic        clk;
    logic        rst;
    logic        bus_req;
    logic        bus_wr;
    logic        bus_rd;
    logic        bus_halt;
    logic        bus_ack;
    logic [7:0]  bus_din;
    logic [7:0]  bus_dout;
    logic        bus_oe;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        halted;
    logic        proto_err;

    int passed = 0;
    int total  = 0;

    int         ready_wait = 0;
    int         rsp_delay  = 3;
    logic [7:0] rsp_data   = 8'h00;

    logic [15:0] rec_addr  [32];
    logic        rec_we    [32];
    logic [7:0]  rec_wdata [32];
    int          rec_n         = 0;
    int          valid_rises   = 0;
    int          valid_cycles  = 0;
    int          stable_err    = 0;
    int          ack_valid_err = 0;
    int          oe_seen       = 0;

    int oe_before_ack = 0;
    int oe_drop       = 0;

    tt_um_aiju_bus_target #(.SYNC_STAGES(2), .DATA_SETUP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_halt   (bus_halt),
        .bus_ack    (bus_ack),
        .bus_din    (bus_din),
        .bus_dout   (bus_dout),
        .bus_oe     (bus_oe),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .halted     (halted),
        .proto_err  (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder and bus monitor; decisions made on the falling edge.
    initial begin : mem_model
        int          wait_cnt;
        int          rsp_cnt;
        logic        prev_valid;
        logic [15:0] held_addr;
        logic        held_we;
        wait_cnt   = 0;
        rsp_cnt    = 0;
        prev_valid = 1'b0;
        held_addr  = '0;
        held_we    = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_oe) oe_seen++;
            if (bus_ack && mem_valid) ack_valid_err++;
            if (mem_valid) begin
                valid_cycles++;
                if (!prev_valid) begin
                    valid_rises++;
                    held_addr = mem_addr;
                    held_we   = mem_we;
                end else if (mem_addr !== held_addr || mem_we !== held_we) begin
                    stable_err++;
                end
            end
            prev_valid = mem_valid;
            mem_rvalid = 1'b0;
            if (rst) begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
                rsp_cnt   = 0;
            end else begin
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rsp_data;
                    end
                end
                if (mem_ready) begin
                    mem_ready = 1'b0;
                end else if (mem_valid) begin
                    if (wait_cnt < ready_wait) begin
                        wait_cnt++;
                    end else begin
                        mem_ready = 1'b1;
                        wait_cnt  = 0;
                        if (rec_n < 32) begin
                            rec_addr[rec_n]  = mem_addr;
                            rec_we[rec_n]    = mem_we;
                            rec_wdata[rec_n] = mem_wdata;
                        end
                        rec_n++;
                        if (!mem_we) rsp_cnt = rsp_delay + 1;
                    end
                end
            end
        end
    end

    task automatic xfer(input logic [7:0] din, input logic wr, input logic rd,
                        output logic [7:0] rdata);
        int   cyc;
        logic oe_at_ack;
        @(negedge clk);
        bus_din = din;
        bus_wr  = wr;
        bus_rd  = rd;
        bus_req = 1'b1;
        cyc = 0;
        while (!bus_ack && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus_oe && !bus_ack) oe_before_ack++;
        end
        total++;
        if (!bus_ack) $display("[TB] FAIL ack_rise_timeout: bus_ack=%b want 1", bus_ack);
        else passed++;
        rdata     = bus_dout;
        oe_at_ack = bus_oe;
        bus_req   = 1'b0;
        cyc = 0;
        while (bus_ack && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus_ack && oe_at_ack && !bus_oe) oe_drop++;
        end
        total++;
        if (bus_ack) $display("[TB] FAIL ack_fall_timeout: bus_ack=%b want 0", bus_ack);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_req = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0; bus_halt = 1'b0; bus_din = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({bus_ack, bus_oe, mem_valid, mem_we, halted, proto_err} !== 6'b0)
            $display("[TB] FAIL reset_ctrl: got %b want 000000",
                     {bus_ack, bus_oe, mem_valid, mem_we, halted, proto_err});
        else passed++;
        total++;
        if ({mem_addr, mem_wdata, bus_dout} !== 32'h0)
            $display("[TB] FAIL reset_data: got %h want 00000000", {mem_addr, mem_wdata, bus_dout});
        else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_halted();
        bus_halt = 1'b1;
        @(negedge clk);
        total++;
        if (halted !== 1'b0) $display("[TB] FAIL halt_sync_early: got %b want 0", halted);
        else passed++;
        @(negedge clk);
        total++;
        if (halted !== 1'b1) $display("[TB] FAIL halt_rise: got %b want 1", halted);
        else passed++;
        bus_halt = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (halted !== 1'b0) $display("[TB] FAIL halt_fall: got %b want 0", halted);
        else passed++;
    endtask

    task automatic test_write();
        int         base;
        int         oe0;
        int         rises0;
        logic [7:0] rd;
        base = rec_n; oe0 = oe_seen; rises0 = valid_rises;
        ready_wait = 0;
        xfer(8'h34, 1'b1, 1'b0, rd);
        xfer(8'h12, 1'b1, 1'b0, rd);
        xfer(8'h5A, 1'b1, 1'b0, rd);
        total++;
        if (rec_n - base !== 1) $display("[TB] FAIL wr_count: got %0d want 1", rec_n - base);
        else passed++;
        total++;
        if (valid_rises - rises0 !== 1) $display("[TB] FAIL wr_pulses: got %0d want 1", valid_rises - rises0);
        else passed++;
        total++;
        if ({rec_we[base], rec_addr[base], rec_wdata[base]} !== {1'b1, 16'h1234, 8'h5A})
            $display("[TB] FAIL wr_req: got we=%b addr=%h data=%h want we=1 addr=1234 data=5a",
                     rec_we[base], rec_addr[base], rec_wdata[base]);
        else passed++;
        total++;
        if (oe_seen - oe0 !== 0) $display("[TB] FAIL wr_oe: got %0d oe cycles want 0", oe_seen - oe0);
        else passed++;
        total++;
        if ({mem_addr, mem_wdata} !== 24'h12345A)
            $display("[TB] FAIL wr_hold: got %h want 12345a", {mem_addr, mem_wdata});
        else passed++;
    endtask

    task automatic test_read();
        int         base;
        logic [7:0] rd;
        base = rec_n;
        rsp_delay = 3; rsp_data = 8'hC3;
        xfer(8'hEF, 1'b0, 1'b1, rd);
        xfer(8'hBE, 1'b0, 1'b1, rd);
        oe_before_ack = 0; oe_drop = 0;
        xfer(8'h00, 1'b0, 1'b1, rd);
        total++;
        if ({rec_we[base], rec_addr[base]} !== {1'b0, 16'hBEEF})
            $display("[TB] FAIL rd_req: got we=%b addr=%h want we=0 addr=beef", rec_we[base], rec_addr[base]);
        else passed++;
        total++;
        if (rd !== 8'hC3) $display("[TB] FAIL rd_data: got %h want c3", rd);
        else passed++;
        total++;
        if (oe_before_ack < 1) $display("[TB] FAIL rd_setup: got %0d oe cycles before ack want >=1", oe_before_ack);
        else passed++;
        total++;
        if (oe_drop !== 0) $display("[TB] FAIL rd_oe_hold: got %0d early drops want 0", oe_drop);
        else passed++;
        total++;
        if (bus_oe !== 1'b0) $display("[TB] FAIL rd_oe_release: got %b want 0", bus_oe);
        else passed++;
    endtask

    task automatic test_backpressure();
        int         base;
        int         vc0;
        int         se0;
        int         av0;
        logic [7:0] rd;
        base = rec_n;
        xfer(8'hAB, 1'b1, 1'b0, rd);
        xfer(8'hCD, 1'b1, 1'b0, rd);
        ready_wait = 10;
        vc0 = valid_cycles; se0 = stable_err; av0 = ack_valid_err;
        xfer(8'h66, 1'b1, 1'b0, rd);
        ready_wait = 0;
        total++;
        if (valid_cycles - vc0 < 11) $display("[TB] FAIL bp_valid_len: got %0d want >=11", valid_cycles - vc0);
        else passed++;
        total++;
        if (stable_err - se0 !== 0) $display("[TB] FAIL bp_stable: got %0d changes want 0", stable_err - se0);
        else passed++;
        total++;
        if (ack_valid_err - av0 !== 0) $display("[TB] FAIL bp_ack_early: got %0d want 0", ack_valid_err - av0);
        else passed++;
        total++;
        if ({rec_we[base], rec_addr[base], rec_wdata[base]} !== {1'b1, 16'hCDAB, 8'h66})
            $display("[TB] FAIL bp_req: got we=%b addr=%h data=%h want we=1 addr=cdab data=66",
                     rec_we[base], rec_addr[base], rec_wdata[base]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int         base;
        logic [7:0] rd;
        base = rec_n;
        rsp_delay = 1; rsp_data = 8'h11;
        xfer(8'h00, 1'b0, 1'b1, rd);
        xfer(8'h00, 1'b0, 1'b1, rd);
        xfer(8'h00, 1'b0, 1'b1, rd);
        xfer(8'h01, 1'b0, 1'b1, rd);
        xfer(8'h00, 1'b0, 1'b1, rd);
        xfer(8'h00, 1'b0, 1'b1, rd);
        total++;
        if (rec_n - base !== 2) $display("[TB] FAIL b2b_count: got %0d want 2", rec_n - base);
        else passed++;
        total++;
        if ({rec_addr[base], rec_addr[base+1]} !== 32'h0000_0001)
            $display("[TB] FAIL b2b_addr: got %h %h want 0000 0001", rec_addr[base], rec_addr[base+1]);
        else passed++;
        total++;
        if ({rec_we[base], rec_we[base+1]} !== 2'b00)
            $display("[TB] FAIL b2b_we: got %b%b want 00", rec_we[base], rec_we[base+1]);
        else passed++;
    endtask

    task automatic test_reset_memreq();
        int         base;
        int         cyc;
        logic [7:0] rd;
        ready_wait = 1000;
        xfer(8'h78, 1'b1, 1'b0, rd);
        xfer(8'h56, 1'b1, 1'b0, rd);
        @(negedge clk);
        bus_din = 8'h99; bus_wr = 1'b1; bus_rd = 1'b0; bus_req = 1'b1;
        cyc = 0;
        while (!mem_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!mem_valid) $display("[TB] FAIL rm_valid_timeout: mem_valid=%b want 1", mem_valid);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({bus_ack, bus_oe, mem_valid, mem_we, mem_addr, mem_wdata} !== 28'h0)
            $display("[TB] FAIL rm_outputs: got %h want 0", {bus_ack, bus_oe, mem_valid, mem_we, mem_addr, mem_wdata});
        else passed++;
        @(negedge clk);
        bus_req = 1'b0; bus_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ready_wait = 0;
        repeat (2) @(negedge clk);
        base = rec_n;
        xfer(8'h22, 1'b1, 1'b0, rd);
        xfer(8'h11, 1'b1, 1'b0, rd);
        xfer(8'h99, 1'b1, 1'b0, rd);
        total++;
        if ({rec_n - base, rec_addr[base]} !== {32'd1, 16'h1122})
            $display("[TB] FAIL rm_after: got count=%0d addr=%h want count=1 addr=1122",
                     rec_n - base, rec_addr[base]);
        else passed++;
    endtask

    task automatic test_reset_ack();
        int         base;
        int         cyc;
        logic [7:0] rd;
        @(negedge clk);
        bus_din = 8'h44; bus_wr = 1'b1; bus_rd = 1'b0; bus_req = 1'b1;
        cyc = 0;
        while (!bus_ack && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!bus_ack) $display("[TB] FAIL ra_ack_timeout: bus_ack=%b want 1", bus_ack);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({bus_ack, bus_oe, mem_valid, mem_we, proto_err} !== 5'b0)
            $display("[TB] FAIL ra_outputs: got %b want 00000", {bus_ack, bus_oe, mem_valid, mem_we, proto_err});
        else passed++;
        @(negedge clk);
        bus_req = 1'b0; bus_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        base = rec_n;
        xfer(8'h02, 1'b1, 1'b0, rd);
        xfer(8'h01, 1'b1, 1'b0, rd);
        xfer(8'h77, 1'b1, 1'b0, rd);
        total++;
        if ({rec_addr[base], rec_wdata[base]} !== 24'h0102_77)
            $display("[TB] FAIL ra_after: got addr=%h data=%h want addr=0102 data=77",
                     rec_addr[base], rec_wdata[base]);
        else passed++;
    endtask

    task automatic test_proto_err();
        int         base;
        logic [7:0] rd;
        base = rec_n;
        rsp_delay = 1; rsp_data = 8'h5E;
        total++;
        if (proto_err !== 1'b0) $display("[TB] FAIL pe_initial: got %b want 0", proto_err);
        else passed++;
        xfer(8'h0D, 1'b1, 1'b1, rd);
        xfer(8'hF0, 1'b1, 1'b1, rd);
        xfer(8'hAA, 1'b1, 1'b1, rd);
        total++;
        if (proto_err !== 1'b1) $display("[TB] FAIL pe_set: got %b want 1", proto_err);
        else passed++;
        total++;
        if ({rec_we[base], rec_addr[base], rd} !== {1'b0, 16'hF00D, 8'h5E})
            $display("[TB] FAIL pe_read: got we=%b addr=%h data=%h want we=0 addr=f00d data=5e",
                     rec_we[base], rec_addr[base], rd);
        else passed++;
        xfer(8'h01, 1'b1, 1'b0, rd);
        xfer(8'h00, 1'b1, 1'b0, rd);
        xfer(8'h3C, 1'b1, 1'b0, rd);
        total++;
        if ({proto_err, rec_we[base+1], rec_addr[base+1]} !== {1'b1, 1'b1, 16'h0001})
            $display("[TB] FAIL pe_sticky: got err=%b we=%b addr=%h want err=1 we=1 addr=0001",
                     proto_err, rec_we[base+1], rec_addr[base+1]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_halted();
        test_write();
        test_read();
        test_backpressure();
        test_back_to_back();
        test_reset_memreq();
        test_reset_ack();
        test_proto_err();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
